// File: rtl/dp_pkg.sv
// Shared definitions for the dp buffer and its port-B reader.
// Contents: default data/address widths and the reader FSM state encoding.
package dp_pkg;

  localparam int DP_DATA_W = 8;
  localparam int DP_ADDR_W = 4;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    CAPT    = 3'd2,
    PRESENT = 3'd3,
    ADV     = 3'd4,
    DONE    = 3'd5
  } state_t;

endpackage

// File: rtl/dp_reader_if.sv
// Valid/ready word stream leaving the dp port-B reader.
//   data_out   : read word (source -> sink)
//   data_valid : data_out holds an unconsumed word (source -> sink)
//   data_ready : sink accepts when data_valid && data_ready (sink -> source)
// Modports: master = stream source (the reader), slave = consumer.
interface dp_reader_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );

endinterface

// File: rtl/dp_reader.sv
// Port-B drain controller for the dp dual-port buffer.
// After start, reads num_words consecutive words from the current port-B
// address by sequencing WEB (load dp output register) and incB (advance
// dp pointer), and offers each word on a valid/ready stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset (shared with dp)
//   start      : one-cycle request, only honoured in IDLE
//   num_words  : word count 0..2**ADDR_W, captured on start accept
//   outB       : dp port-B read data, valid the cycle after WEB
//   WEB, incB  : dp port-B controls, never asserted together
//   rd_addr    : mirror of the dp port-B address (wraps)
//   busy       : high in every state except IDLE
//   done       : one-cycle pulse when the transfer completes
//   strm       : data_out / data_valid / data_ready stream (master side)
module dp_reader
  import dp_pkg::*;
#(
  parameter int DATA_W = DP_DATA_W,
  parameter int ADDR_W = DP_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W:0]   num_words,
  input  logic [DATA_W-1:0] outB,
  output logic              WEB,
  output logic              incB,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              busy,
  output logic              done,
  dp_reader_if.master       strm
);

  state_t          state;
  logic [ADDR_W:0] remaining;

  // Every output is loaded together with the state it belongs to, so all
  // outputs are flops and data_ready never reaches WEB/incB combinationally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      WEB             <= 1'b0;
      incB            <= 1'b0;
      rd_addr         <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      remaining       <= '0;
      strm.data_out   <= '0;
      strm.data_valid <= 1'b0;
    end else begin
      WEB  <= 1'b0;
      incB <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy <= 1'b1;
            if (num_words == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              remaining <= num_words;
              state     <= LOAD;
              WEB       <= 1'b1;
            end
          end
        end
        LOAD: begin
          state <= CAPT;
        end
        CAPT: begin
          strm.data_out   <= outB;
          strm.data_valid <= 1'b1;
          state           <= PRESENT;
        end
        PRESENT: begin
          // data_valid is known high here, so ready alone completes the handshake
          if (strm.data_ready) begin
            strm.data_valid <= 1'b0;
            incB            <= 1'b1;
            state           <= ADV;
          end
        end
        ADV: begin
          rd_addr   <= rd_addr + ADDR_W'(1);
          remaining <= remaining - (ADDR_W+1)'(1);
          if (remaining == (ADDR_W+1)'(1)) begin
            state <= DONE;
            done  <= 1'b1;
          end else begin
            state <= LOAD;
            WEB   <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state           <= IDLE;
          busy            <= 1'b0;
          strm.data_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dp_reader.sv
module tb_dp_reader;
  import dp_pkg::*;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW:0]   num_words = '0;
  logic [DW-1:0] outb;
  logic          web, incb, busy, done;
  logic [AW-1:0] rd_addr;

  dp_reader_if #(.DATA_W(DW)) strm ();

  dp_reader #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num_words (num_words),
    .outB      (outb),
    .WEB       (web),
    .incB      (incb),
    .rd_addr   (rd_addr),
    .busy      (busy),
    .done      (done),
    .strm      (strm)
  );

  always #5 clk = ~clk;

  // Behavioural dp port B: registered read on WEB, pointer advance on incB.
  logic [DW-1:0] mem [DEPTH];
  logic [AW-1:0] ptrb;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptrb <= '0;
      outb <= '0;
    end else begin
      if (web)  outb <= mem[ptrb];
      if (incb) ptrb <= ptrb + 1'b1;
    end
  end

  // Reference model state: expected words in order and expected read address.
  logic [DW-1:0] expq [$];
  int model_addr = 0;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: event counters, word scoreboard, hold-stability during stalls.
  int web_cnt = 0, incb_cnt = 0, done_cnt = 0, words_seen = 0;
  logic          hold_pend = 1'b0;
  logic [DW-1:0] hold_val  = '0;

  always @(negedge clk) begin
    if (rst) begin
      hold_pend = 1'b0;
    end else begin
      if (web)  web_cnt++;
      if (incb) incb_cnt++;
      if (done) done_cnt++;
      if (web || incb) check("web_incb_exclusive", 32'(web && incb), 0);
      if (incb) check("incb_while_valid", 32'(strm.data_valid), 0);
      if (hold_pend) begin
        check("hold_valid", 32'(strm.data_valid), 1);
        check("hold_data", 32'(strm.data_out), 32'(hold_val));
      end
      if (strm.data_valid && strm.data_ready) begin
        if (expq.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_word: got %0d expected none", strm.data_out);
        end else begin
          check("word", 32'(strm.data_out), 32'(expq.pop_front()));
        end
        words_seen++;
        hold_pend = 1'b0;
      end else if (strm.data_valid) begin
        hold_pend = 1'b1;
        hold_val  = strm.data_out;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  // Consumer: mode 0 always ready, mode 1 random, mode 2 stalls word 1 for 5 cycles.
  int ready_mode = 0;
  int xfer_base  = 0;
  int stall_cnt  = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0: strm.data_ready = 1'b1;
      1: strm.data_ready = ($urandom_range(0, 2) != 0);
      default: begin
        if (strm.data_valid && (words_seen - xfer_base) == 1) begin
          if (stall_cnt < 5) begin
            strm.data_ready = 1'b0;
            stall_cnt++;
          end else begin
            strm.data_ready = 1'b1;
          end
        end else begin
          stall_cnt = 0;
          strm.data_ready = 1'b1;
        end
      end
    endcase
  end

  task automatic check_idle_outputs(input string tag);
    check({tag, "_web"},        32'(web), 0);
    check({tag, "_incb"},       32'(incb), 0);
    check({tag, "_data_out"},   32'(strm.data_out), 0);
    check({tag, "_data_valid"}, 32'(strm.data_valid), 0);
    check({tag, "_rd_addr"},    32'(rd_addr), 0);
    check({tag, "_busy"},       32'(busy), 0);
    check({tag, "_done"},       32'(done), 0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    model_addr = 0;
    #1;
    check_idle_outputs("reset");
  endtask

  task automatic randomize_mem();
    for (int i = 0; i < DEPTH; i++) mem[i] = DW'($urandom);
  endtask

  // One transfer of n words; latency checks only when the consumer never stalls.
  task automatic run_xfer(input int n, input int mode, input bit inject);
    int  wb0, ib0, dn0, ws0, start_addr, lat, busy_cnt, fv, inj;
    bit  got;
    ready_mode = mode;
    @(negedge clk);
    start_addr = model_addr;
    for (int i = 0; i < n; i++) expq.push_back(mem[(start_addr + i) % DEPTH]);
    wb0 = web_cnt; ib0 = incb_cnt; dn0 = done_cnt; ws0 = words_seen;
    xfer_base = words_seen;
    start     = 1'b1;
    num_words = (AW+1)'(n);
    @(posedge clk);
    #1 start = 1'b0;
    got = 0; lat = -1; busy_cnt = 0; fv = -1; inj = 0;
    for (int c = 1; c <= 4000 && !got; c++) begin
      @(negedge clk);
      if (busy) busy_cnt++;
      if (strm.data_valid && fv < 0) fv = c - 1;
      if (inj == 1) begin
        start = 1'b0;
        inj   = 2;
      end else if (inject && inj == 0 && strm.data_valid) begin
        start     = 1'b1;
        num_words = (AW+1)'(7);
        inj       = 1;
      end
      if (done) begin
        got = 1;
        lat = c - 1;
      end
    end
    start = 1'b0;
    if (!got) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: no done within 4000 cycles for n=%0d", n);
    end
    model_addr = (start_addr + n) % DEPTH;
    @(negedge clk);
    #1;
    check("done_cleared", 32'(done), 0);
    check("busy_cleared", 32'(busy), 0);
    check("web_pulses",   32'(web_cnt - wb0), 32'(n));
    check("incb_pulses",  32'(incb_cnt - ib0), 32'(n));
    check("done_pulses",  32'(done_cnt - dn0), 1);
    check("words",        32'(words_seen - ws0), 32'(n));
    check("queue_empty",  32'(expq.size()), 0);
    check("rd_addr",      32'(rd_addr), 32'(model_addr));
    check("busy_cycles",  32'(busy_cnt), 32'(lat + 1));
    if (mode == 0) begin
      check("done_latency", 32'(lat), 32'(4 * n));
      if (n > 0) check("first_valid_latency", 32'(fv), 2);
    end
    if (inject) begin
      repeat (3) @(negedge clk);
      #1;
      check("inject_no_restart", 32'(busy), 0);
      check("inject_done_count", 32'(done_cnt - dn0), 1);
    end
  endtask

  initial begin
    randomize_mem();
    // Power-on reset
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check_idle_outputs("reset");

    // Directed: words 0..8, four words at full rate
    for (int i = 0; i < 9; i++) mem[i] = DW'(i);
    run_xfer(4, 0, 1'b0);

    // Same words with a 5-cycle stall on word 1
    do_reset();
    run_xfer(4, 2, 1'b0);

    // Zero-length transfer
    run_xfer(0, 0, 1'b0);

    // Advance to address 14, then wrap across the end of the buffer
    randomize_mem();
    run_xfer(10, 1, 1'b0);
    run_xfer(4, 0, 1'b0);

    // start pulse during PRESENT is ignored
    randomize_mem();
    run_xfer(3, 0, 1'b1);

    // Full depth returns rd_addr to its start value
    randomize_mem();
    run_xfer(16, 1, 1'b0);

    // Randomized transfers
    for (int k = 0; k < 8; k++) begin
      randomize_mem();
      run_xfer(int'($urandom_range(0, DEPTH)), int'($urandom_range(0, 2)),
               1'($urandom_range(0, 1)));
    end

    // Asynchronous reset in the middle of a transfer
    begin
      int  waited;
      randomize_mem();
      ready_mode = 0;
      @(negedge clk);
      for (int i = 0; i < 6; i++) expq.push_back(mem[(model_addr + i) % DEPTH]);
      start     = 1'b1;
      num_words = (AW+1)'(6);
      @(posedge clk);
      #1 start = 1'b0;
      waited = 0;
      while (!strm.data_valid && waited < 100) begin
        @(negedge clk);
        waited++;
      end
      check("midreset_reached_present", 32'(strm.data_valid), 1);
      @(posedge clk);
      #3 rst = 1'b1;
      #1;
      check_idle_outputs("midreset");
      expq.delete();
      @(negedge clk);
      rst = 1'b0;
      model_addr = 0;
    end
    randomize_mem();
    run_xfer(2, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
